aes_share_stream_mux: RTL and testbench

Registered, handshaked N-way selector for masked AES datapath inputs: key words, IV and ciphertext, or any other SHARES-way masked 128-bit source. It forwards one source's shares per beat to the cipher core. Selection is either explicit (sel_i) or round-robin among valid sources, and is locked for a whole multi-beat transfer until the beat marked last. All shares of a beat move together, and the output register is zeroised whenever it holds no valid beat.

---
 rtl/aes_mux_pkg.sv | 20 ++
 rtl/aes_rr_arbiter.sv | 44 ++++
 rtl/aes_share_stream_mux.sv | 166 ++++++++++++++++
 tb/tb_aes_share_stream_mux.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_mux_pkg.sv
// Shared definitions for the masked AES input stream selector.
//   mux_state_e   : transfer FSM states (IDLE = free to arbitrate,
//                   LOCKED = mid multi-beat transfer, grant frozen)
//   MODE_*        : values of mode_i
//   SRC_*         : source indices historically used for key / IV / ciphertext
package aes_mux_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } mux_state_e;

    localparam logic MODE_EXPLICIT = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    localparam int SRC_KEY = 0;
    localparam int SRC_IV  = 1;
    localparam int SRC_CT  = 2;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request searching upward from rr_ptr_i+1,
// wrapping past NUM_SRC-1 back to 0.
//   req_i         : request vector, one bit per source
//   rr_ptr_i      : index of the most recently served source
//   grant_o       : winning source index (0 when nothing requests)
//   grant_valid_o : at least one request is asserted
module aes_rr_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int SELW    = $clog2(NUM_SRC + 1)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SELW-1:0]    rr_ptr_i,
    output logic [SELW-1:0]    grant_o,
    output logic               grant_valid_o
);

    // Requests strictly above the pointer take precedence; if there are
    // none, the lowest request overall wins, which is the wrapped search.
    logic [NUM_SRC-1:0] upper_req;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_upper
            assign upper_req[gi] = req_i[gi] && (SELW'(gi) > rr_ptr_i);
        end
    endgenerate

    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_o       = SELW'(i);
                grant_valid_o = 1'b1;
            end
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
                grant_o = SELW'(i);
            end
        end
    end

endmodule

// File: rtl/aes_share_stream_mux.sv
// Registered, handshaked N-way selector for masked AES datapath inputs.
// Forwards all shares of one source per beat, with explicit or round-robin
// selection, locked for a whole transfer until the beat flagged last.
// The output register is cleared whenever it holds no valid beat so that
// no stale share material lingers on d_o.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   src_data_i    : per-source shares [source][share]
//   src_valid_i   : per-source beat valid
//   src_last_i    : per-source final-beat flag
//   src_ready_o   : per-source accept (combinational)
//   mode_i        : 0 explicit select via sel_i, 1 round-robin
//   sel_i         : explicit source index; NUM_SRC and above select nothing
//   d_o, last_o   : registered output beat
//   valid_o       : output register holds a beat
//   ready_i       : downstream accept
//   grant_o       : current / locked source index, NUM_SRC when none
//   busy_o        : a multi-beat transfer is in progress
module aes_share_stream_mux
    import aes_mux_pkg::*;
#(
    parameter int SHARES  = 3,
    parameter int WIDTH   = 128,
    parameter int NUM_SRC = 3,
    parameter int SELW    = $clog2(NUM_SRC + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   src_data_i [0:NUM_SRC-1][0:SHARES-1],
    input  logic [NUM_SRC-1:0] src_valid_i,
    input  logic [NUM_SRC-1:0] src_last_i,
    output logic [NUM_SRC-1:0] src_ready_o,
    input  logic               mode_i,
    input  logic [SELW-1:0]    sel_i,
    output logic [WIDTH-1:0]   d_o [0:SHARES-1],
    output logic               last_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [SELW-1:0]    grant_o,
    output logic               busy_o
);

    localparam logic [SELW-1:0] GRANT_NONE = SELW'(NUM_SRC);
    localparam logic [SELW-1:0] RR_RESET   = SELW'(NUM_SRC - 1);

    mux_state_e       state_reg;
    mux_state_e       state_next;
    logic [SELW-1:0]  locked_grant_reg;
    logic [SELW-1:0]  rr_ptr_reg;
    logic             valid_reg;
    logic             last_reg;
    logic [WIDTH-1:0] d_reg [0:SHARES-1];

    logic [SELW-1:0]    arb_grant;
    logic               arb_grant_valid;
    logic [SELW-1:0]    grant;
    logic [NUM_SRC-1:0] grant_onehot;
    logic               can_load;
    logic               sel_valid;
    logic               sel_last;
    logic               accept;
    logic [WIDTH-1:0]   sel_data [0:SHARES-1];

    aes_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SELW    (SELW)
    ) u_arbiter (
        .req_i         (src_valid_i),
        .rr_ptr_i      (rr_ptr_reg),
        .grant_o       (arb_grant),
        .grant_valid_o (arb_grant_valid)
    );

    // Grant: frozen while LOCKED, otherwise chosen by mode.
    always_comb begin
        grant = GRANT_NONE;
        if (state_reg == ST_LOCKED) begin
            grant = locked_grant_reg;
        end else if (mode_i == MODE_RR) begin
            if (arb_grant_valid) begin
                grant = arb_grant;
            end
        end else if (sel_i < GRANT_NONE) begin
            grant = sel_i;
        end
    end

    // The output register can take a new beat when empty or draining now.
    assign can_load = !valid_reg || ready_i;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
            assign grant_onehot[gi] = (grant == SELW'(gi));
            assign src_ready_o[gi]  = grant_onehot[gi] && can_load;
        end
    endgenerate

    assign sel_valid = |(grant_onehot & src_valid_i);
    assign sel_last  = |(grant_onehot & src_last_i);
    assign accept    = sel_valid && can_load;

    // Share s always comes from share s of the granted source; shares are
    // muxed independently and never combined.
    always_comb begin
        for (int s = 0; s < SHARES; s++) begin
            sel_data[s] = '0;
            for (int g = 0; g < NUM_SRC; g++) begin
                if (grant_onehot[g]) begin
                    sel_data[s] = src_data_i[g][s];
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept && !sel_last) state_next = ST_LOCKED;
            ST_LOCKED: if (accept && sel_last)  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_grant_reg <= '0;
            rr_ptr_reg       <= RR_RESET;
            valid_reg        <= 1'b0;
            last_reg         <= 1'b0;
            for (int s = 0; s < SHARES; s++) begin
                d_reg[s] <= '0;
            end
        end else if (accept) begin
            valid_reg  <= 1'b1;
            last_reg   <= sel_last;
            rr_ptr_reg <= grant;
            for (int s = 0; s < SHARES; s++) begin
                d_reg[s] <= sel_data[s];
            end
            if (state_reg == ST_IDLE && !sel_last) begin
                locked_grant_reg <= grant;
            end
        end else if (ready_i && valid_reg) begin
            // Beat consumed with nothing behind it: wipe the shares.
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            for (int s = 0; s < SHARES; s++) begin
                d_reg[s] <= '0;
            end
        end
    end

    assign d_o     = d_reg;
    assign last_o  = last_reg;
    assign valid_o = valid_reg;
    assign grant_o = grant;
    assign busy_o  = (state_reg == ST_LOCKED);

endmodule

// File: tb/tb_aes_share_stream_mux.sv
module tb_aes_share_stream_mux;

    localparam int N    = 3;
    localparam int S    = 3;
    localparam int W    = 128;
    localparam int SELW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   src_data [0:N-1][0:S-1];
    logic [N-1:0]   src_valid;
    logic [N-1:0]   src_last;
    logic [N-1:0]   src_ready;
    logic           mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]   d [0:S-1];
    logic           last;
    logic           valid;
    logic           ready;
    logic [SELW-1:0] grant;
    logic           busy;

    aes_share_stream_mux #(
        .SHARES  (S),
        .WIDTH   (W),
        .NUM_SRC (N),
        .SELW    (SELW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .src_data_i  (src_data),
        .src_valid_i (src_valid),
        .src_last_i  (src_last),
        .src_ready_o (src_ready),
        .mode_i      (mode),
        .sel_i       (sel),
        .d_o         (d),
        .last_o      (last),
        .valid_o     (valid),
        .ready_i     (ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the output register contents and the transfer lock.
    bit         m_valid;
    bit         m_last;
    logic [W-1:0] m_d [0:S-1];
    bit         m_locked;
    int         m_lsrc;
    int         m_rr;
    bit         auto_src;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_valid  = 0;
        m_last   = 0;
        m_locked = 0;
        m_lsrc   = 0;
        m_rr     = N - 1;
        for (int s = 0; s < S; s++) m_d[s] = '0;
    endtask

    // Whom the block should be serving right now (N = nobody).
    function automatic int model_grant();
        if (m_locked) return m_lsrc;
        if (mode) begin
            for (int k = 1; k <= N; k++) begin
                if (src_valid[(m_rr + k) % N]) return (m_rr + k) % N;
            end
            return N;
        end
        return (int'(sel) < N) ? int'(sel) : N;
    endfunction

    task automatic refill(input int s);
        src_valid[s] = ($urandom_range(0, 2) != 0);
        src_last[s]  = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < S; k++) src_data[s][k] = rnd128();
    endtask

    // One clock cycle: check combinational outputs, clock, check registers.
    task automatic step();
        int g;
        bit can;
        bit acc;
        logic [N-1:0] exp_rdy;
        #1;
        g       = model_grant();
        can     = !m_valid || ready;
        exp_rdy = '0;
        acc     = 0;
        if (g < N) begin
            if (can) exp_rdy[g] = 1'b1;
            acc = can && src_valid[g];
        end
        check("src_ready", W'(src_ready), W'(exp_rdy));
        check("grant", W'(grant), W'(g));
        check("busy", W'(busy), W'(m_locked));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (acc) begin
            m_valid = 1;
            m_last  = src_last[g];
            for (int s = 0; s < S; s++) m_d[s] = src_data[g][s];
            if (!m_locked && !src_last[g]) begin
                m_locked = 1;
                m_lsrc   = g;
            end else if (m_locked && src_last[g]) begin
                m_locked = 0;
            end
            m_rr = g;
        end else if (ready && m_valid) begin
            m_valid = 0;
            m_last  = 0;
            for (int s = 0; s < S; s++) m_d[s] = '0;
        end
        #1;
        check("valid", W'(valid), W'(m_valid));
        check("last", W'(last), W'(m_last));
        for (int s = 0; s < S; s++) check($sformatf("d%0d", s), d[s], m_d[s]);
        if (auto_src) begin
            for (int s = 0; s < N; s++) begin
                if ((acc && !rst && g == s) || !src_valid[s]) refill(s);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        logic [W-1:0] held;
        rst       = 1;
        mode      = 0;
        sel       = 0;
        ready     = 1;
        src_valid = '0;
        src_last  = '0;
        auto_src  = 0;
        for (int g = 0; g < N; g++)
            for (int s = 0; s < S; s++) src_data[g][s] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();
        check("rst_valid", W'(valid), W'(0));

        // Explicit select of source 1, single beat with shares A,B,C.
        mode = 0; sel = 1; src_valid = 3'b010; src_last = 3'b010;
        src_data[1][0] = 128'hA; src_data[1][1] = 128'hB; src_data[1][2] = 128'hC;
        #1 check("expl_ready", W'(src_ready), W'(3'b010));
        step();
        check("expl_d1", d[1], W'(128'hB));
        check("expl_last", W'(last), W'(1));
        src_valid = '0;
        step();
        check("expl_zero", d[2], W'(0));

        // Locked 4-beat key transfer, sel moves to CT after beat 1.
        mode = 0; sel = 0; src_valid = 3'b001; src_last = 3'b000;
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < S; s++) src_data[0][s] = W'(16 * b + s + 1);
            if (b == 3) src_last[0] = 1;
            step();
            if (b == 0) begin
                sel = 2; src_valid[2] = 1; src_last[2] = 1;
                for (int s = 0; s < S; s++) src_data[2][s] = W'(32'hC700 + s);
            end
            check("lock_busy", W'(busy), W'(b < 3));
            check("lock_d0", d[0], W'(16 * b + 1));
        end
        src_valid[0] = 0;
        #1 check("ct_grant", W'(grant), W'(2));
        step();
        check("ct_d0", d[0], W'(32'hC700));
        src_valid = '0;
        step();

        // Backpressure: 5 stalled cycles hold the beat.
        src_valid = 3'b100; src_last = 3'b100; ready = 1;
        step();
        held = d[1];
        ready = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold", d[1], held);
        end
        ready = 1;
        src_valid = '0;
        step();

        // Out-of-range select with everyone valid.
        mode = 0; sel = 3; src_valid = 3'b111; src_last = 3'b111;
        step();
        check("oor_grant", W'(grant), W'(3));
        check("oor_valid", W'(valid), W'(0));

        // Round-robin from reset: 0,1,2,0,1,2.
        do_reset();
        mode = 1;
        for (int i = 0; i < 6; i++) begin
            #1 check("rr_seq", W'(grant), W'(i % 3));
            step();
        end

        // Reset during a locked transfer after 2 of 4 beats.
        do_reset();
        mode = 0; sel = 0; src_valid = 3'b001; src_last = 3'b000;
        step();
        step();
        check("mid_busy", W'(busy), W'(1));
        do_reset();
        check("mid_idle", W'(busy), W'(0));
        check("mid_valid", W'(valid), W'(0));
        mode = 1; src_last = 3'b001;
        #1 check("mid_grant", W'(grant), W'(0));
        step();

        // Randomized traffic with occasional reset.
        auto_src = 1;
        for (int g = 0; g < N; g++) refill(g);
        for (int i = 0; i < 3000; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            sel = SELW'($urandom_range(0, 3));
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
